matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the 3x4 · 4x3 byte-matrix multiply datapath. It assembles two 12-byte operands from a byte stream onto a shared 96-bit staging bus and pulses the load strobes of the A and B operand registers. It then walks the 9 output elements, driving operand-select indices and MAC control for each, and hands each result downstream with a valid/ready handshake. The operand registers have no reset, so this block alone decides when they hold valid data.

## Interface
- No parameters; dimensions fixed at M=3, K=4, N=3.
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- in_valid  in  1  in_data carries a byte.
- in_data  in  8  operand byte, row-major: A first (12 bytes), then B (12 bytes).
- in_ready  out  1  block accepts in_data this cycle.
- stage_data  out  96  assembled bytes; byte n on bits [8n+7:8n], feeds Din(n+1) of both operand registers.
- ldA  out  1  one-cycle load strobe for the A operand register.
- ldB  out  1  one-cycle load strobe for the B operand register.
- a_idx  out  4  A byte select, = 4i+k.
- b_idx  out  4  B byte select, = 3k+j.
- mac_en  out  1  accumulate the product this cycle.
- mac_first  out  1  with mac_en: acc <= product; otherwise acc <= acc+product.
- out_valid  out  1  accumulator holds C[out_row][out_col].
- out_ready  in  1  downstream accepts the result.
- out_row  out  2  i of the presented result.
- out_col  out  2  j of the presented result.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, LOAD_A, LATCH_A, LOAD_B, LATCH_B, CALC, EMIT, DONE.
- IDLE: all strobes 0. If start=1, go to LOAD_A and clear byte counter cnt.
- LOAD_A / LOAD_B: in_ready=1. On in_valid&in_ready, write in_data to stage_data byte cnt and increment cnt. The 12th accept (cnt=11) moves to LATCH_A / LATCH_B.
- LATCH_A: in_ready=0, ldA=1 for exactly one cycle, cnt cleared, go to LOAD_B. LATCH_B: ldB=1, go to CALC with i=j=k=0. stage_data is stable throughout each LATCH cycle.
- CALC: mac_en=1, a_idx=4i+k, b_idx=3k+j, mac_first=(k==0). k increments each cycle. After k=3, go to EMIT with k cleared.
- EMIT: out_valid=1, out_row=i, out_col=j, held until out_ready=1.
  - On handshake, if i=2 and j=2, go to DONE.
  - Otherwise advance j; if j wraps 2→0, increment i. Return to CALC.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. in_valid with in_ready=0 is ignored; the byte is not consumed.
- ldA and ldB never assert on a partially assembled operand.

## Timing
- Reset (async assert, released synchronously to CLK) forces:
  - state=IDLE, cnt=i=j=k=0, stage_data=0;
  - in_ready, ldA, ldB, mac_en, mac_first, out_valid, busy, done = 0;
  - a_idx=b_idx=0, out_row=out_col=0.
- Reset mid-job aborts with no ld strobe. Operand registers keep stale contents; a new start reloads both.
- The accumulator registers on the mac_en edge, so the result is valid in the EMIT cycle that directly follows k=3.
- Unstalled job: 1 (start) + 12 + 1 + 12 + 1 + 9×(4+1) + 1 = 73 cycles from start sampled to done.
- Each out_ready stall cycle adds one cycle. Each in_valid=0 cycle during a load adds one cycle.
- busy rises the cycle after start is sampled and falls the cycle after done.

## Test plan
- Load A=1..12, B=1..12 with continuous in_valid and out_ready=1, using a behavioural register+MAC model. Required: ldA exactly once and ldB exactly once; results in order (0,0)…(2,2) = 70,80,90,158,184,210,246,288,330; done at cycle 73.
- Check the index sequence for output (1,2). Required: a_idx 4,5,6,7; b_idx 2,5,8,11; mac_first only on the first of the four cycles.
- Gap injection: deassert in_valid every other cycle. Required: stage_data bytes land in order, ldA/ldB each still a single pulse, results unchanged.
- Backpressure: hold out_ready=0 for 5 cycles on result (0,1). Required: out_valid, out_row=0, out_col=1 held stable; no mac_en during the stall; done delayed by 5 cycles.
- Assert reset after the 7th byte of B. Required: all outputs 0 immediately and no ldB. Then pulse start and load A=12..1, B=1..12; required C(0,0)=12+44+70+90=216.
- Pulse start during CALC. Required: ignored, job completes normally, busy stays high.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 3x4 * 4x3 byte-matrix multiply: assembles A/B operands from a
// byte stream, strobes the operand registers, then drives MAC control per output element.
module matmul_seq_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [95:0] stage_data,
  output logic        ldA,
  output logic        ldB,
  output logic [3:0]  a_idx,
  output logic [3:0]  b_idx,
  output logic        mac_en,
  output logic        mac_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_row,
  output logic [1:0]  out_col,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LATCH_A, S_LOAD_B, S_LATCH_B, S_CALC, S_EMIT, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_i, r_j, r_k;
  logic [95:0] r_stage;
  logic        w_accept;
  logic        w_last;

  assign w_last     = (r_i == 2'd2) && (r_j == 2'd2);
  assign stage_data = r_stage;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    w_accept  = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    a_idx     = '0;
    b_idx     = '0;
    mac_en    = 1'b0;
    mac_first = 1'b0;
    out_valid = 1'b0;
    out_row   = '0;
    out_col   = '0;
    done      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD_A;
      S_LOAD_A: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && r_cnt == 4'd11) w_next = S_LATCH_A;
      end
      S_LATCH_A: begin
        ldA    = 1'b1;
        w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && r_cnt == 4'd11) w_next = S_LATCH_B;
      end
      S_LATCH_B: begin
        ldB    = 1'b1;
        w_next = S_CALC;
      end
      S_CALC: begin
        mac_en    = 1'b1;
        mac_first = (r_k == 2'd0);
        a_idx     = {r_i, r_k};
        b_idx     = {2'b00, r_k} * 4'd3 + {2'b00, r_j};
        if (r_k == 2'd3) w_next = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_row   = r_i;
        out_col   = r_j;
        if (out_ready) w_next = w_last ? S_DONE : S_CALC;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt <= '0;
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
        end
        S_LOAD_A, S_LOAD_B: if (w_accept) begin
          r_stage[{r_cnt, 3'b000} +: 8] <= in_data;
          r_cnt                         <= r_cnt + 4'd1;
        end
        S_LATCH_A: r_cnt <= '0;
        S_LATCH_B: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        // k wraps 3->0 on its own, leaving it cleared for the next element
        S_CALC: r_k <= r_k + 2'd1;
        S_EMIT: if (out_ready && !w_last) begin
          if (r_j == 2'd2) begin
            r_j <= '0;
            r_i <= r_i + 2'd1;
          end else begin
            r_j <= r_j + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl with an external operand-register/MAC model
// and matrix-arithmetic reference results.
module tb_matmul_seq_ctrl;

  logic        CLK = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic [95:0] stage_data;
  logic        ldA, ldB, mac_en, mac_first, out_valid, out_ready, busy, done;
  logic [3:0]  a_idx, b_idx;
  logic [1:0]  out_row, out_col;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  matmul_seq_ctrl dut (
    .CLK(CLK), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stage_data(stage_data), .ldA(ldA), .ldB(ldB),
    .a_idx(a_idx), .b_idx(b_idx), .mac_en(mac_en), .mac_first(mac_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  // Downstream datapath: unreset operand registers and accumulator
  logic [95:0] mA, mB;
  logic [7:0]  w_pa, w_pb;
  logic [31:0] macc;
  assign w_pa = mA[{a_idx, 3'b000} +: 8];
  assign w_pb = mB[{b_idx, 3'b000} +: 8];
  always @(posedge CLK) begin
    if (ldA) mA <= stage_data;
    if (ldB) mB <= stage_data;
    if (mac_en) macc <= (mac_first ? 32'd0 : macc) + {24'd0, w_pa} * {24'd0, w_pb};
  end

  byte unsigned opA[12];
  byte unsigned opB[12];
  int lit[9] = '{70, 80, 90, 158, 184, 210, 246, 288, 330};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] cexp(input int r, input int c);
    int unsigned s = 0;
    for (int k = 0; k < 4; k++) s += opA[4*r+k] * opB[3*k+c];
    return {64'd0, s};
  endfunction

  function automatic logic [95:0] pack(input bit isB);
    logic [95:0] v = '0;
    for (int n = 0; n < 12; n++) v[8*n +: 8] = isB ? opB[n] : opA[n];
    return v;
  endfunction

  task automatic run_job(input bit gaps, input int stall_idx, input int stall_len,
                         input int abort_b, input bit start_calc, input bit use_lit);
    int edges = 0, sent = 0, nres = 0, kk = 0, stall_cnt = 0, gapcnt = 0, nla = 0, nlb = 0;
    bit done_seen = 0, tog = 0;
    start = 1; in_valid = 0; out_ready = 1;
    while (!done_seen && edges < 3000) begin
      @(posedge CLK); @(negedge CLK);
      edges++;
      start = 0;
      if (ldA) begin nla++; chk("ldA_bytes", sent, 12); chk("stageA", stage_data, pack(0)); end
      if (ldB) begin nlb++; chk("ldB_bytes", sent, 24); chk("stageB", stage_data, pack(1)); end
      if (abort_b > 0 && sent == 12 + abort_b) begin
        reset = 1; in_valid = 0;
        #1;
        chk("abort_outs", {in_ready, ldA, ldB, mac_en, mac_first, out_valid, busy, done,
                           a_idx, b_idx, out_row, out_col}, '0);
        chk("abort_stage", stage_data, '0);
        chk("abort_noldB", nlb, 0);
        @(negedge CLK);
        reset = 0;
        return;
      end
      if (mac_en) begin
        if (nres == 5) begin
          chk("idx12_a", a_idx, 4 + kk);
          chk("idx12_b", b_idx, 2 + 3*kk);
          chk("idx12_first", mac_first, kk == 0);
        end
        if (start_calc && nres == 3 && kk == 1) start = 1;
        kk++;
      end
      if (out_valid) begin
        chk("row", out_row, nres / 3);
        chk("col", out_col, nres % 3);
        chk("result", macc, cexp(nres / 3, nres % 3));
        if (use_lit) chk("result_lit", macc, lit[nres]);
        if (start_calc) chk("busy_hold", busy, 1);
        if (nres == stall_idx && stall_cnt < stall_len) begin
          chk("stall_nomac", mac_en, 0);
          out_ready = 0;
          stall_cnt++;
        end else begin
          out_ready = 1;
          nres++;
          kk = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (in_ready && sent < 24) begin
        tog = ~tog;
        if (gaps && tog) begin
          in_valid = 0; in_data = 8'($urandom); gapcnt++;
        end else begin
          in_valid = 1;
          in_data  = (sent < 12) ? opA[sent] : opB[sent-12];
          sent++;
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      if (done) begin
        done_seen = 1;
        chk("done_cycle", edges + 1, 73 + stall_len + gapcnt);
        chk("done_busy", busy, 1);
      end
    end
    chk("done_seen", done_seen, 1);
    chk("ldA_once", nla, 1);
    chk("ldB_once", nlb, 1);
    chk("n_results", nres, 9);
    in_valid = 0; out_ready = 1;
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (2) @(negedge CLK);
    chk("rst_outs", {in_ready, ldA, ldB, mac_en, mac_first, out_valid, busy, done,
                     a_idx, b_idx, out_row, out_col}, '0);
    chk("rst_stage", stage_data, '0);
    reset = 0;
    @(negedge CLK);

    for (int n = 0; n < 12; n++) begin opA[n] = 8'(n + 1); opB[n] = 8'(n + 1); end
    run_job(0, -1, 0, 0, 0, 1);
    run_job(1, -1, 0, 0, 0, 1);
    run_job(0, 1, 5, 0, 0, 1);
    run_job(0, -1, 0, 7, 0, 0);
    for (int n = 0; n < 12; n++) opA[n] = 8'(12 - n);
    run_job(0, -1, 0, 0, 0, 0);
    for (int n = 0; n < 12; n++) opA[n] = 8'(n + 1);
    run_job(0, -1, 0, 0, 1, 1);
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 12; n++) begin opA[n] = 8'($urandom); opB[n] = 8'($urandom); end
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 4), 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
